// File: rtl/rr_arb_stage.sv
// rr_arb_stage: registered round-robin arbiter that merges N valid/ready lanes
// into one output beat per cycle, feeding a downstream skid buffer.
// Optional packet lock (per-lane last_in / registered last_out) is built when
// the macro ARB_LOCK_EN is defined; the default build arbitrates every beat.
module rr_arb_stage #(
  parameter int unsigned N  = 4,
  parameter int unsigned DW = 8,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    valid_in,
  input  logic [N*DW-1:0] data_in,
`ifdef ARB_LOCK_EN
  input  logic [N-1:0]    last_in,
  output logic            last_out,
`endif
  output logic [N-1:0]    ready_out,
  output logic            valid_out,
  output logic [DW-1:0]   data_out,
  input  logic            ready_in,
  output logic [IW-1:0]   grant_id
);

  logic [IW-1:0] ptr_q, ptr_d;
  logic          valid_q, valid_d;
  logic [DW-1:0] data_q, data_d;
  logic [IW-1:0] gid_q, gid_d;
`ifdef ARB_LOCK_EN
  logic          lock_q, lock_d;
  logic [IW-1:0] lock_lane_q, lock_lane_d;
  logic          last_q, last_d;
`endif

  logic [DW-1:0] lane_data [N];
  logic          load;
  logic          accept;
  logic          win_found;
  logic [IW-1:0] win_idx;
  logic [IW-1:0] scan_idx;
  logic [IW-1:0] ptr_inc;

  // Unpack the flat data bus into per-lane words
  always_comb begin
    for (int i = 0; i < int'(N); i++) begin
      lane_data[i] = data_in[i*int'(DW) +: DW];
    end
  end

  // Output register may load when empty or when its beat is being taken
  assign load   = !valid_q || ready_in;
  assign accept = load && win_found;

  // Round-robin scan from ptr; a held lock restricts eligibility to one lane
  always_comb begin
    win_found = 1'b0;
    win_idx   = '0;
    scan_idx  = '0;
`ifdef ARB_LOCK_EN
    if (lock_q) begin
      win_found = valid_in[lock_lane_q];
      win_idx   = lock_lane_q;
    end else begin
`endif
      for (int i = 0; i < int'(N); i++) begin
        scan_idx = IW'((int'(ptr_q) + i) % int'(N));
        if (!win_found && valid_in[scan_idx]) begin
          win_found = 1'b1;
          win_idx   = scan_idx;
        end
      end
`ifdef ARB_LOCK_EN
    end
`endif
  end

  // Pointer position just past the winner, wrapping at N-1
  assign ptr_inc = (win_idx == IW'(N - 1)) ? '0 : win_idx + IW'(1);

  // Grant the winner only when the output stage can take it; silent in reset
  always_comb begin
    ready_out = '0;
    if (rst && accept) begin
      ready_out[win_idx] = 1'b1;
    end
  end

  // Next-state for the output stage, pointer and lock
  always_comb begin
    ptr_d   = ptr_q;
    valid_d = valid_q;
    data_d  = data_q;
    gid_d   = gid_q;
`ifdef ARB_LOCK_EN
    lock_d      = lock_q;
    lock_lane_d = lock_lane_q;
    last_d      = last_q;
`endif
    if (load) begin
      if (win_found) begin
        valid_d = 1'b1;
        data_d  = lane_data[win_idx];
        gid_d   = win_idx;
`ifdef ARB_LOCK_EN
        last_d = last_in[win_idx];
        if (last_in[win_idx]) begin
          lock_d = 1'b0;
          ptr_d  = ptr_inc;
        end else begin
          lock_d      = 1'b1;
          lock_lane_d = win_idx;
        end
`else
        ptr_d = ptr_inc;
`endif
      end else begin
        valid_d = 1'b0;
      end
    end
  end

  // State registers, cleared asynchronously
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ptr_q   <= '0;
      valid_q <= 1'b0;
      data_q  <= '0;
      gid_q   <= '0;
`ifdef ARB_LOCK_EN
      lock_q      <= 1'b0;
      lock_lane_q <= '0;
      last_q      <= 1'b0;
`endif
    end else begin
      ptr_q   <= ptr_d;
      valid_q <= valid_d;
      data_q  <= data_d;
      gid_q   <= gid_d;
`ifdef ARB_LOCK_EN
      lock_q      <= lock_d;
      lock_lane_q <= lock_lane_d;
      last_q      <= last_d;
`endif
    end
  end

  assign valid_out = valid_q;
  assign data_out  = data_q;
  assign grant_id  = gid_q;
`ifdef ARB_LOCK_EN
  assign last_out  = last_q;
`endif

endmodule

// File: tb/tb_rr_arb_stage.sv
// Directed bench for rr_arb_stage with a beat scoreboard.
module tb_rr_arb_stage;

  localparam int unsigned N  = 4;
  localparam int unsigned DW = 8;
  localparam int unsigned IW = 2;

  logic            clk;
  logic            rst;
  logic [N-1:0]    valid_in;
  logic [N*DW-1:0] data_in;
  logic [N-1:0]    ready_out;
  logic            valid_out;
  logic [DW-1:0]   data_out;
  logic            ready_in;
  logic [IW-1:0]   grant_id;
`ifdef ARB_LOCK_EN
  logic [N-1:0]    last_in;
  logic            last_out;
`endif

  int checks   = 0;
  int failures = 0;
  logic [23:0] sb_q [$];   // {last, gid, data}

  rr_arb_stage #(.N(N), .DW(DW)) dut (
    .clk       (clk),
    .rst       (rst),
    .valid_in  (valid_in),
    .data_in   (data_in),
`ifdef ARB_LOCK_EN
    .last_in   (last_in),
    .last_out  (last_out),
`endif
    .ready_out (ready_out),
    .valid_out (valid_out),
    .data_out  (data_out),
    .ready_in  (ready_in),
    .grant_id  (grant_id)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_lane(input int k, input logic [7:0] d);
    data_in[k*8 +: 8] = d;
  endtask

  task automatic push(input logic [7:0] last, input logic [7:0] gid, input logic [7:0] d);
    sb_q.push_back({last, gid, d});
  endtask

  // Score the beat consumed at the coming edge, then advance one cycle
  task automatic tick();
    logic [23:0] e;
    #2;
    if (valid_out && ready_in) begin
      if (sb_q.size() == 0) begin
        chk("sb_underflow", sb_q.size(), 1);
      end else begin
        e = sb_q.pop_front();
        chk("beat_data", 32'(data_out), 32'(e[7:0]));
        chk("beat_gid", 32'(grant_id), 32'(e[15:8]));
`ifdef ARB_LOCK_EN
        chk("beat_last", 32'(last_out), 32'(e[23:16]));
`endif
      end
    end
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst      = 1'b0;
    valid_in = 4'b1111;
    data_in  = '0;
    ready_in = 1'b1;
    set_lane(0, 8'h10); set_lane(1, 8'h20); set_lane(2, 8'h30); set_lane(3, 8'h40);
`ifdef ARB_LOCK_EN
    last_in = 4'b1111;
`endif

    // Reset held with all lanes requesting
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(valid_out), 0);
    chk("rst_data", 32'(data_out), 0);
    chk("rst_gid", 32'(grant_id), 0);
    chk("rst_ready", 32'(ready_out), 0);

    // Release: lane 0 first, full-rate rotation
    rst = 1'b1;
    push(0, 0, 8'h10); push(0, 1, 8'h20); push(0, 2, 8'h30); push(0, 3, 8'h40);
    push(0, 0, 8'h10); push(0, 1, 8'h20); push(0, 2, 8'h30);
    #1;
    chk("first_grant", 32'(ready_out), 32'b0001);
    chk("pre_latency_valid", 32'(valid_out), 0);
    tick();
    chk("latency_valid", 32'(valid_out), 1);
    chk("latency_data", 32'(data_out), 32'h10);
    repeat (5) tick();
    chk("rr_data", 32'(data_out), 32'h20);

    // Backpressure holds the beat stable
    ready_in = 1'b0;
    #1;
    chk("bp_ready", 32'(ready_out), 0);
    for (int c = 0; c < 3; c++) begin
      tick();
      chk("bp_data", 32'(data_out), 32'h20);
      chk("bp_valid", 32'(valid_out), 1);
      chk("bp_gid", 32'(grant_id), 1);
      chk("bp_ready_hold", 32'(ready_out), 0);
    end
    ready_in = 1'b1;
    #1;
    chk("bp_release_ready", 32'(ready_out), 32'b0100);
    tick();
    valid_in = 4'b0000;
    tick();
    chk("idle_valid", 32'(valid_out), 0);
    chk("idle_data_hold", 32'(data_out), 32'h30);
    chk("idle_gid_hold", 32'(grant_id), 2);

    // Single lane back-to-back
    valid_in = 4'b0100;
    set_lane(2, 8'h01);
    push(0, 2, 8'h01); push(0, 2, 8'h02); push(0, 2, 8'h03);
    #1;
    chk("single_ready", 32'(ready_out), 32'b0100);
    tick();
    set_lane(2, 8'h02);
    tick();
    chk("single_valid", 32'(valid_out), 1);
    set_lane(2, 8'h03);
    tick();
    chk("single_valid2", 32'(valid_out), 1);
    valid_in = 4'b0000;
    tick();
    chk("single_drain", 32'(valid_out), 0);

    // Wrap: ptr=3, lanes 1 and 3 requesting
    valid_in = 4'b1010;
    set_lane(1, 8'hA1); set_lane(3, 8'hB3);
    push(0, 3, 8'hB3); push(0, 1, 8'hA1); push(0, 3, 8'hB3);
    #1;
    chk("wrap_first", 32'(ready_out), 32'b1000);
    tick();
    chk("wrap_second", 32'(ready_out), 32'b0010);
    tick();
    valid_in = 4'b1000;
    tick();
    valid_in = 4'b0000;
    #1;
    chk("idle_ready", 32'(ready_out), 0);
    tick();
    chk("wrap_idle_valid", 32'(valid_out), 0);

    // Reset during a pending beat discards it at once
    valid_in = 4'b0001;
    set_lane(0, 8'h55);
    tick();
    chk("pre_abort_valid", 32'(valid_out), 1);
    rst = 1'b0;
    #1;
    chk("abort_valid", 32'(valid_out), 0);
    chk("abort_data", 32'(data_out), 0);
    chk("abort_ready", 32'(ready_out), 0);
    valid_in = 4'b0000;
    tick();
    rst = 1'b1;

`ifdef ARB_LOCK_EN
    // Lane 1 three-beat packet holds off lane 2
    valid_in = 4'b0110;
    last_in  = 4'b0100;
    set_lane(1, 8'hC1); set_lane(2, 8'hD2);
    push(0, 1, 8'hC1); push(0, 1, 8'hC2); push(1, 1, 8'hC3); push(1, 2, 8'hD2);
    tick();
    #1;
    chk("lock_ready", 32'(ready_out), 32'b0010);
    set_lane(1, 8'hC2);
    tick();
    set_lane(1, 8'hC3);
    last_in = 4'b0110;
    tick();
    valid_in = 4'b0100;
    tick();
    valid_in = 4'b0000;
    tick();
`endif

    chk("sb_empty", sb_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
